// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory port: FSM encoding, header layout.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Direction flag carried by the first header bit on the wire
  localparam logic DIR_WRITE = 1'b1;

  // Header is one direction bit followed by the start address
  function automatic int unsigned hdr_len(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Data-phase shift register shared by the read (serialise) and write
// (deserialise) paths; bit order on the wire selected by MSB_FIRST.
module spi_shift_reg #(
  parameter int unsigned DATA_W    = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              shift_i,
  input  logic              sin_i,
  output logic              sout_o,
  output logic [DATA_W-1:0] shift_val_o
);

  logic [DATA_W-1:0] sr_q, sr_d;

  // Value after one serial step; the write path captures it as the full word
  always_comb begin
    if (MSB_FIRST) shift_val_o = {sr_q[DATA_W-2:0], sin_i};
    else           shift_val_o = {sin_i, sr_q[DATA_W-1:1]};
  end

  // Parallel load wins over shifting
  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = load_val_i;
    else if (shift_i) sr_d = shift_val_o;
  end

  // Shift register state
  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign sout_o = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];

endmodule

// File: rtl/spi_mem_port.sv
// SPI-slave memory port: header (direction + start address) followed by a
// stream of whole words with auto-incrementing, wrapping addresses.
module spi_mem_port
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_flag,
  input  logic              sel,
  input  logic              rising,
  input  logic              falling,
  input  logic              si,
  output logic              so,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int unsigned HDR_LEN = hdr_len(ADDR_W);
  localparam int unsigned CNT_MAX = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_LEN-1:0]  hdr_q, hdr_d, hdr_next;
  logic [DATA_W-1:0]   pref_q, pref_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;

  logic                sr_load;
  logic [DATA_W-1:0]   sr_load_val;
  logic                sr_shift;
  logic                sr_sout;
  logic [DATA_W-1:0]   sr_shift_val;

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk_i       (clk),
    .rst_i       (reset_flag),
    .load_i      (sr_load),
    .load_val_i  (sr_load_val),
    .shift_i     (sr_shift),
    .sin_i       (si),
    .sout_o      (sr_sout),
    .shift_val_o (sr_shift_val)
  );

  // Next-state logic: header decode, read serialisation, write assembly
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    pref_d      = pref_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    sr_load     = 1'b0;
    sr_load_val = '0;
    sr_shift    = 1'b0;
    hdr_next    = {hdr_q[HDR_LEN-2:0], si};

    if (!sel) begin
      // Frame ended: any partial word is dropped, address and data held
      state_d = ST_HDR;
      cnt_d   = CNT_HDR;
    end else begin
      unique case (state_q)
        ST_HDR: begin
          if (rising) begin
            hdr_d = hdr_next;
            if (cnt_q == '0) begin
              addr_d  = hdr_next[ADDR_W-1:0];
              // Clear so the data phase starts from a known, quiet value
              sr_load = 1'b1;
              if (hdr_next[HDR_LEN-1] == DIR_WRITE) begin
                state_d = ST_WRITE;
                cnt_d   = CNT_DATA;
              end else begin
                // Zero count makes the first falling strobe a word load
                state_d = ST_READ;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_READ: begin
          pref_d = rd_data;
          // A falling strobe coinciding with rising is a violation; ignore it
          if (falling && !rising) begin
            if (cnt_q == '0) begin
              sr_load     = 1'b1;
              sr_load_val = pref_q;
              cnt_d       = CNT_DATA;
              addr_d      = addr_q + ADDR_W'(1);
            end else begin
              sr_shift = 1'b1;
              cnt_d    = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (wr_en_q) addr_d = addr_q + ADDR_W'(1);
          if (rising) begin
            sr_shift = 1'b1;
            if (cnt_q == '0) begin
              wr_en_d   = 1'b1;
              wr_data_d = sr_shift_val;
              cnt_d     = CNT_DATA;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_HDR;
          cnt_d   = CNT_HDR;
        end
      endcase
    end

    busy_d = (state_d != ST_HDR);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset_flag) begin
      state_q   <= ST_HDR;
      addr_q    <= '0;
      cnt_q     <= CNT_HDR;
      hdr_q     <= '0;
      pref_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      pref_q    <= pref_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign so      = (state_q == ST_READ) & sr_sout;
  assign addr    = addr_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_mem_port.sv
// Bench for spi_mem_port: frame-level SPI master, RAM model with write log,
// and a word-level reference memory for expected read/write traffic.
module tb_spi_mem_port;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_flag, sel, rising, falling, si;
  logic so0, so1, wr_en0, wr_en1, busy0, busy1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rd_data0, rd_data1, wr_data0, wr_data1;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic [AW-1:0] log_a [$];
  logic [DW-1:0] log_d [$];

  int n_pass  = 0;
  int n_total = 0;
  logic s0, s1;

  spi_mem_port #(.DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset_flag(reset_flag), .sel(sel), .rising(rising),
    .falling(falling), .si(si), .so(so0), .addr(addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_data(wr_data0), .busy(busy0)
  );

  spi_mem_port #(.DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset_flag(reset_flag), .sel(sel), .rising(rising),
    .falling(falling), .si(si), .so(so1), .addr(addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_data(wr_data1), .busy(busy1)
  );

  // Synchronous RAMs with one-cycle read latency; dut0 writes are logged
  always @(posedge clk) begin
    rd_data0 <= mem0[addr0];
    if (wr_en0) begin
      mem0[addr0] <= wr_data0;
      log_a.push_back(addr0);
      log_d.push_back(wr_data0);
    end
  end

  always @(posedge clk) begin
    rd_data1 <= mem1[addr1];
    if (wr_en1) mem1[addr1] <= wr_data1;
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    int            n;
    logic [47:0]   w;      // words in wire order, first word in the top 16 bits
    logic [AW-1:0] a_end;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] pick(input logic [47:0] s, input int k);
    return 16'(s >> (32 - 16 * k));
  endfunction

  task automatic rise(input logic b);
    @(negedge clk);
    s0 = so0;
    s1 = so1;
    si = b;
    rising = 1'b1;
    @(negedge clk);
    rising = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fall();
    @(negedge clk);
    falling = 1'b1;
    @(negedge clk);
    falling = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic open_frame(input logic wr, input logic [AW-1:0] a);
    logic [AW:0] h;
    @(negedge clk);
    sel = 1'b1;
    repeat (2) @(negedge clk);
    h = {wr, a};
    for (int i = 0; i <= int'(AW); i++) begin
      if (i > 0) fall();
      rise(h[AW]);
      h = h << 1;
    end
    chk("busy_in_frame", 32'(busy0), 32'd1);
  endtask

  task automatic close_frame();
    @(negedge clk);
    sel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Data clocks: falling then rising; so sampled just before each rising
  task automatic data_bits(input logic [47:0] tx, input int nbits,
                           output logic [47:0] r0, output logic [47:0] r1);
    logic [47:0] t;
    t  = tx;
    r0 = '0;
    r1 = '0;
    for (int k = 0; k < nbits; k++) begin
      fall();
      rise(t[47]);
      t  = t << 1;
      r0 = {r0[46:0], s0};
      r1 = {r1[46:0], s1};
    end
    if (nbits > 0) begin
      r0 = r0 << (48 - nbits);
      r1 = r1 << (48 - nbits);
    end
  endtask

  task automatic run_vec(input logic wr, input logic [AW-1:0] a, input int n,
                         input logic [47:0] tx, input logic [AW-1:0] a_end, input string tag);
    int base;
    logic [47:0] r0, r1;
    base = log_a.size();
    open_frame(wr, a);
    data_bits(tx, n * 16, r0, r1);
    repeat (2) @(negedge clk);
    chk($sformatf("%s_addr_end", tag), 32'(addr0), 32'(a_end));
    if (wr) begin
      chk($sformatf("%s_wr_count", tag), 32'(log_a.size()), 32'(base + n));
      for (int k = 0; k < n; k++) begin
        if (base + k < log_a.size()) begin
          chk($sformatf("%s_wr_addr%0d", tag, k), 32'(log_a[base + k]), 32'(AW'(a + AW'(k))));
          chk($sformatf("%s_wr_data%0d", tag, k), 32'(log_d[base + k]), 32'(pick(tx, k)));
        end
        model_mem[AW'(a + AW'(k))] = pick(tx, k);
      end
    end else begin
      for (int k = 0; k < n; k++)
        chk($sformatf("%s_rd_word%0d", tag, k), 32'(pick(r0, k)), 32'(pick(tx, k)));
    end
    close_frame();
    chk($sformatf("%s_idle", tag), 32'(busy0), 32'd0);
  endtask

  initial begin
    logic [47:0] r0, r1, tx;
    logic [15:0] rx;
    logic [AW-1:0] a;
    logic wr;
    int n, base;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem0[i] <= 16'(i * 32'h1111);
      mem1[i] <= 16'(i + 1);
      model_mem[i] = 16'(i * 32'h1111);
    end

    vecs[0] = '{wr: 1'b0, a: 12'h005, n: 3, w: {16'h5555, 16'h6666, 16'h7777}, a_end: 12'h008};
    vecs[1] = '{wr: 1'b1, a: 12'hFFF, n: 2, w: {16'hA5A5, 16'h3C3C, 16'h0000}, a_end: 12'h001};
    vecs[2] = '{wr: 1'b0, a: 12'hFFF, n: 2, w: {16'hA5A5, 16'h3C3C, 16'h0000}, a_end: 12'h001};
    vecs[3] = '{wr: 1'b0, a: 12'h00F, n: 1, w: {16'hFFFF, 32'h0},             a_end: 12'h010};
    vecs[4] = '{wr: 1'b1, a: 12'h123, n: 1, w: {16'hBEEF, 32'h0},             a_end: 12'h124};
    vecs[5] = '{wr: 1'b0, a: 12'h122, n: 2, w: {16'h5542, 16'hBEEF, 16'h0000}, a_end: 12'h124};

    reset_flag = 1'b1;
    sel = 1'b0;
    rising = 1'b0;
    falling = 1'b0;
    si = 1'b0;
    repeat (3) @(negedge clk);
    reset_flag = 1'b0;
    @(negedge clk);
    chk("reset_addr",    32'(addr0),    32'd0);
    chk("reset_so",      32'(so0),      32'd0);
    chk("reset_busy",    32'(busy0),    32'd0);
    chk("reset_wr_en",   32'(wr_en0),   32'd0);
    chk("reset_wr_data", 32'(wr_data0), 32'd0);
    chk("reset_busy_lsb_dut", 32'(busy1), 32'd0);

    // LSB-first instance: word 0x0001 at address 0 goes out as 1 then fifteen 0s
    open_frame(1'b0, 12'h000);
    data_bits(48'h0, 16, r0, r1);
    chk("lsb_first_stream", 32'(pick(r1, 0)), 32'h8000);
    chk("msb_first_word0",  32'(pick(r0, 0)), 32'h0000);
    chk("lsb_first_addr",   32'(addr1),       32'h001);
    close_frame();

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i].wr, vecs[i].a, vecs[i].n, vecs[i].w, vecs[i].a_end, $sformatf("vec%0d", i));

    // Write frame abandoned after 9 data bits
    base = log_a.size();
    open_frame(1'b1, 12'h040);
    data_bits({16'hFFFF, 32'h0}, 9, r0, r1);
    close_frame();
    chk("abort_no_write", 32'(log_a.size()), 32'(base));
    chk("abort_addr",     32'(addr0),        32'h040);
    chk("abort_idle",     32'(busy0),        32'd0);
    run_vec(1'b0, 12'h007, 1, {16'h7777, 32'h0}, 12'h008, "after_abort");

    // Rising and falling in the same clk mid-word: falling must be ignored
    open_frame(1'b0, 12'h00A);
    rx = '0;
    for (int k = 0; k < 3; k++) begin
      fall();
      rise(1'b0);
      rx = {rx[14:0], s0};
    end
    @(negedge clk);
    si = 1'b0;
    rising = 1'b1;
    falling = 1'b1;
    @(negedge clk);
    rising = 1'b0;
    falling = 1'b0;
    repeat (2) @(negedge clk);
    chk("collide_addr", 32'(addr0), 32'h00B);
    chk("collide_so",   32'(so0),   32'd1);
    for (int k = 0; k < 13; k++) begin
      fall();
      rise(1'b0);
      rx = {rx[14:0], s0};
    end
    chk("collide_word", 32'(rx), 32'hAAAA);
    close_frame();

    // Reset pulse in the middle of a read
    open_frame(1'b0, 12'h005);
    data_bits(48'h0, 5, r0, r1);
    @(negedge clk);
    reset_flag = 1'b1;
    @(negedge clk);
    reset_flag = 1'b0;
    chk("midreset_addr", 32'(addr0), 32'd0);
    chk("midreset_so",   32'(so0),   32'd0);
    chk("midreset_busy", 32'(busy0), 32'd0);
    close_frame();
    run_vec(1'b0, 12'h006, 1, {16'h6666, 32'h0}, 12'h007, "after_reset");

    // Random frames checked against the reference memory
    for (int r = 0; r < 10; r++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      n  = int'($urandom_range(1, 3));
      tx = '0;
      for (int k = 0; k < 3; k++) begin
        tx = tx << 16;
        if (k < n) tx[15:0] = wr ? 16'($urandom) : model_mem[AW'(a + AW'(k))];
      end
      run_vec(wr, a, n, tx, AW'(a + AW'(n)), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_mem_port.md
# spi_mem_port

Parametrised SPI-slave memory port: bridges an SPI bitstream, already reduced to `sel`/`rising`/`falling`/`si` strobes in the `clk` domain, to a single-port synchronous word memory. A frame opens with a header carrying the read/write direction and a start address. The frame then streams whole words with auto-incrementing, wrapping addresses: reads serialise memory words onto `so`, writes deserialise `si` into memory writes. It replaces the fixed 16-bit read-only controller and sits between the SPI edge detector and the sample/config RAMs.

## Interface
- `DATA_W`, 16: memory word width, ≥2.
- `ADDR_W`, 12: address width; addresses wrap modulo 2^ADDR_W.
- `MSB_FIRST`, 1: 1 = bit DATA_W-1 first on the wire, 0 = bit 0 first (data phase only; header always MSB first).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_flag`  in  1  synchronous, active-high reset.
- `sel`  in  1  chip select, active high, synchronised; low = no frame.
- `rising`  in  1  one-clk strobe, SCK rising edge (sample `si`).
- `falling`  in  1  one-clk strobe, SCK falling edge (update `so`).
- `si`  in  1  serial data in.
- `so`  out  1  serial data out.
- `addr`  out  ADDR_W  memory address.
- `rd_data`  in  DATA_W  memory read data, valid 1 clk after `addr` changes.
- `wr_en`  out  1  one-clk write strobe.
- `wr_data`  out  DATA_W  write word, valid with `wr_en`.
- `busy`  out  1  high while in READ or WRITE.

## Operation
- States: HDR, READ, WRITE. Reset state HDR.
- Reset (`reset_flag`), highest priority: state HDR, `addr`=0, `so`=0, `wr_en`=0, `wr_data`=0, shift register=0, bit counter reloaded, `busy`=0.
- `sel` low: state forced to HDR and bit counter reloaded the following clk. `addr`, `wr_data` and the prefetch register are held. Strobes are ignored. A partial write word is discarded (no `wr_en`).
- HDR: on each `sel & rising`, shift `si` into a 1+ADDR_W header register, MSB first. Header bit 0 on the wire is the direction (1 = write). The remaining ADDR_W bits are the start address.
  - On the rising strobe of the last header bit: `addr` <= start address. State becomes READ or WRITE.
- READ:
  - The prefetch register captures `rd_data` on every clk in READ.
  - On the first `sel & falling`: shift register <= prefetch register, bit counter = DATA_W-1, `addr` <= `addr`+1.
  - On each later `sel & falling`: shift one bit. When the counter reaches 0 on that falling strobe, reload from the prefetch register and increment `addr` instead of shifting.
  - `so` = MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register. `so`=0 in HDR and in WRITE.
- WRITE:
  - Each `sel & rising` shifts `si` in, honouring `MSB_FIRST`.
  - On the DATA_W-th bit: `wr_data` <= assembled word and `wr_en`=1 for one clk at the current `addr`. `addr` increments on the clk after `wr_en`.
- Address arithmetic: ADDR_W-bit unsigned. 2^ADDR_W-1 +1 wraps to 0 with no flag.
- `rising` and `falling` in the same clk is a protocol violation: `rising` is processed and `falling` is ignored.

## Timing
- Strobes are spaced ≥3 clk apart. This guarantees the prefetch register holds the word at the new `addr` before the next load.
- `so` changes 1 clk after the `falling` strobe (registered) and is stable through the next `rising`.
- Write latency: `wr_en` is asserted 1 clk after the rising strobe of the last data bit. `addr` advances 1 clk after `wr_en`.
- State transition from HDR is 1 clk after the last header rising strobe. HDR re-entry is 1 clk after `sel` falls or `reset_flag` is asserted.
- `busy` is registered and equals (state != HDR).

## Structure
- Shared package `spi_pkg`: state encoding (ST_HDR, ST_READ, ST_WRITE), direction bit constant (DIR_WRITE=1), and header length function HDR_LEN = 1+ADDR_W.
- One sub-module, `spi_shift_reg`: DATA_W wide, with parallel load, serial in, serial out, `MSB_FIRST` direction, and shift enable. Instantiated once and shared by the read and write paths, since they are mutually exclusive.
- FSM, bit counter, header register, prefetch register and address counter live in the top level.

## Test plan
All scenarios use defaults (DATA_W=16, ADDR_W=12), 4 clk per SCK half-period.
- Reset mid-READ: assert `reset_flag` for 1 clk -> `addr`=0, `so`=0, `busy`=0, state HDR. Next frame works normally.
- Read at 0x005, memory[i] = i*0x1111: 48 data clocks -> `so` streams 0x5555, 0x6666, 0x7777 MSB first. `addr` ends at 0x008.
- Write at 0xFFF, data 0xA5A5 then 0x3C3C -> `wr_en` pulses at `addr` 0xFFF with 0xA5A5, then at 0x000 with 0x3C3C (wrap).
- MSB_FIRST=0, read 0x0001 at `addr` 0 -> first `so` bit is 1, followed by fifteen 0s.
- Write frame with `sel` dropped after 9 data bits -> no `wr_en`, `addr` unchanged, state HDR. The next header is decoded correctly.
- `rising` and `falling` asserted in the same clk during READ -> shift register and `addr` unchanged by `falling`.
